// File: rtl/instr_sequencer.sv
// instr_sequencer
// Program store and issue stage for the 8-register datapath processor.
// A register-array program of 32-bit words is issued one word per cycle as
// operate/addr1/addr2/addr3. WAIT (opcode E) and HALT (opcode F) are handled
// here and appear downstream only as NOP. A CONF (opcode 2) on the outputs
// lets the processor's jump flag skip the next word.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   start      pulse, begin execution at address 0 from IDLE or HALT
//   stop       pulse, force HALT from RUN or WAIT
//   load_en    program write strobe, honoured only in IDLE or HALT
//   load_addr  program write address
//   load_data  program word {operate, addr1, addr2, addr3}
//   jump       processor compare result for the issued instruction
//   operate    issued operate byte
//   addr1..3   issued register addresses
//   pc         address of the word currently on the outputs
//   running    high in RUN or WAIT
//   halted     high in HALT
//
// state | meaning
// IDLE  | after reset, outputs NOP, waiting for start
// RUN   | issuing one instruction per cycle
// WAIT  | issuing NOP until wait_cnt reaches zero
// HALT  | program ended or stopped, pc held, waiting for start

module instr_sequencer #(
    parameter int unsigned AW     = 6,
    parameter logic [7:0]  NOP_OP = 8'h50
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          jump,
    output logic [7:0]    operate,
    output logic [7:0]    addr1,
    output logic [7:0]    addr2,
    output logic [7:0]    addr3,
    output logic [AW-1:0] pc,
    output logic          running,
    output logic          halted
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_HALT
    } state_t;

    state_t        state;
    logic [7:0]    wait_cnt;
    logic [31:0]   mem [2**AW];

    logic          load_ok;
    logic          stop_hit;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic [31:0]   fetch_word;

    always_comb begin
        load_ok    = load_en && (state == ST_IDLE || state == ST_HALT);
        stop_hit   = stop && (state == ST_RUN || state == ST_WAIT);
        fetch_en   = 1'b0;
        fetch_addr = pc + AW'(1);
        case (state)
            ST_IDLE, ST_HALT: begin
                // a start coinciding with a program write is dropped
                if (start && !load_en) begin
                    fetch_en   = 1'b1;
                    fetch_addr = '0;
                end
            end
            ST_RUN: begin
                fetch_en = 1'b1;
                // jump only matters while a CONF is on the outputs
                if (operate[7:4] == 4'h2 && jump) begin
                    fetch_addr = pc + AW'(2);
                end
            end
            ST_WAIT: begin
                fetch_en = (wait_cnt == 8'd0);
            end
            default: begin
                fetch_en = 1'b0;
            end
        endcase
        if (stop_hit) begin
            fetch_en = 1'b0;
        end
        fetch_word = mem[fetch_addr];
    end

    // Program memory is deliberately left out of reset so a program survives it.
    always_ff @(posedge clk) begin
        if (rst_n && load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc       <= '0;
            wait_cnt <= 8'd0;
            operate  <= NOP_OP;
            addr1    <= 8'd0;
            addr2    <= 8'd0;
            addr3    <= 8'd0;
            running  <= 1'b0;
            halted   <= 1'b0;
        end else if (stop_hit) begin
            state   <= ST_HALT;
            operate <= NOP_OP;
            addr1   <= 8'd0;
            addr2   <= 8'd0;
            addr3   <= 8'd0;
            running <= 1'b0;
            halted  <= 1'b1;
        end else if (fetch_en) begin
            pc <= fetch_addr;
            case (fetch_word[31:28])
                4'hF: begin
                    state   <= ST_HALT;
                    operate <= NOP_OP;
                    addr1   <= 8'd0;
                    addr2   <= 8'd0;
                    addr3   <= 8'd0;
                    running <= 1'b0;
                    halted  <= 1'b1;
                end
                4'hE: begin
                    // count of W[23:16] plus the fetch cycle itself gives W+1 NOPs
                    state    <= ST_WAIT;
                    wait_cnt <= fetch_word[23:16];
                    operate  <= NOP_OP;
                    addr1    <= 8'd0;
                    addr2    <= 8'd0;
                    addr3    <= 8'd0;
                    running  <= 1'b1;
                    halted   <= 1'b0;
                end
                default: begin
                    state   <= ST_RUN;
                    operate <= fetch_word[31:24];
                    addr1   <= fetch_word[23:16];
                    addr2   <= fetch_word[15:8];
                    addr3   <= fetch_word[7:0];
                    running <= 1'b1;
                    halted  <= 1'b0;
                end
            endcase
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt - 8'd1;
        end
    end

endmodule
